// File: rtl/mux2_share_arbiter.sv
// Round-robin owner of a shared mux2 datapath; holds off grant for a settle interval after every select change.
// Optional per-requester grant and preemption statistics when MUX2_ARB_STATS_EN is defined.
module mux2_share_arbiter #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned MAX_HOLD      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    output logic [1:0]  gnt,
    output logic        sel,
    output logic        valid,
`ifdef MUX2_ARB_STATS_EN
    output logic        busy,
    output logic [15:0] gnt_cnt0,
    output logic [15:0] gnt_cnt1,
    output logic [7:0]  preempt_cnt
`else
    output logic        busy
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        GRANT  = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);
    localparam logic [7:0] HOLD_LAST   = 8'(MAX_HOLD - 1);
    localparam logic [7:0] HOLD_SAT    = 8'(MAX_HOLD);

    state_t      state_q, state_d;
    logic [3:0]  settle_cnt_q, settle_cnt_d;
    logic [7:0]  hold_cnt_q, hold_cnt_d;
    logic        sel_q, sel_d;
    logic        last_owner_q, last_owner_d;
    logic [1:0]  gnt_q, gnt_d;
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;

    logic        any_req;
    logic        winner;
    logic        owner;
    logic        other;
    logic        preempt;

    always_comb begin
        any_req = |req;
        unique case (req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last_owner_q;
            default: winner = sel_q;
        endcase
    end

    always_comb begin
        // NOTE: every _d gets a hold/default value first so no path through the case infers a latch.
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        sel_d        = sel_q;
        last_owner_d = last_owner_q;
        gnt_d        = 2'b00;
        owner        = sel_q;
        other        = ~sel_q;
        preempt      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    if (winner == sel_q) begin
                        gnt_d      = sel_q ? 2'b10 : 2'b01;
                        hold_cnt_d = 8'd0;
                        state_d    = GRANT;
                    end else begin
                        sel_d        = winner;
                        settle_cnt_d = SETTLE_LOAD;
                        state_d      = SETTLE;
                    end
                end
            end

            SETTLE: begin
                settle_cnt_d = settle_cnt_q - 4'd1;
                if (settle_cnt_q == 4'd1) begin
                    if (req[sel_q]) begin
                        gnt_d        = sel_q ? 2'b10 : 2'b01;
                        hold_cnt_d   = 8'd0;
                        settle_cnt_d = 4'd0;
                        state_d      = GRANT;
                    end else if (any_req) begin
                        // Target gave up while settling; the only remaining requester is the other side.
                        sel_d        = winner;
                        settle_cnt_d = SETTLE_LOAD;
                    end else begin
                        settle_cnt_d = 4'd0;
                        state_d      = IDLE;
                    end
                end
            end

            GRANT: begin
                gnt_d = gnt_q;
                if (hold_cnt_q < HOLD_SAT) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
                // >= rather than == so a requester arriving after saturation is not starved.
                preempt = req[owner] && req[other] && (hold_cnt_q >= HOLD_LAST);
                if (!req[owner] || preempt) begin
                    gnt_d        = 2'b00;
                    hold_cnt_d   = 8'd0;
                    last_owner_d = owner;
                    if (req[other]) begin
                        sel_d        = other;
                        settle_cnt_d = SETTLE_LOAD;
                        state_d      = SETTLE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        valid_d = |gnt_d;
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge value of its neighbours.
        if (rst) begin
            state_q      <= IDLE;
            settle_cnt_q <= 4'd0;
            hold_cnt_q   <= 8'd0;
            sel_q        <= 1'b0;
            last_owner_q <= 1'b1;
            gnt_q        <= 2'b00;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            sel_q        <= sel_d;
            last_owner_q <= last_owner_d;
            gnt_q        <= gnt_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
        end
    end

    assign gnt   = gnt_q;
    assign sel   = sel_q;
    assign valid = valid_q;
    assign busy  = busy_q;

`ifdef MUX2_ARB_STATS_EN
    logic [15:0] gnt_cnt0_q, gnt_cnt0_d;
    logic [15:0] gnt_cnt1_q, gnt_cnt1_d;
    logic [7:0]  preempt_cnt_q, preempt_cnt_d;
    logic        grant_entry;

    always_comb begin
        grant_entry   = (state_d == GRANT) && (state_q != GRANT);
        gnt_cnt0_d    = gnt_cnt0_q;
        gnt_cnt1_d    = gnt_cnt1_q;
        preempt_cnt_d = preempt_cnt_q;
        if (grant_entry && gnt_d[0] && (gnt_cnt0_q != 16'hFFFF)) begin
            gnt_cnt0_d = gnt_cnt0_q + 16'd1;
        end
        if (grant_entry && gnt_d[1] && (gnt_cnt1_q != 16'hFFFF)) begin
            gnt_cnt1_d = gnt_cnt1_q + 16'd1;
        end
        if (preempt && (preempt_cnt_q != 8'hFF)) begin
            preempt_cnt_d = preempt_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_cnt0_q    <= 16'd0;
            gnt_cnt1_q    <= 16'd0;
            preempt_cnt_q <= 8'd0;
        end else begin
            gnt_cnt0_q    <= gnt_cnt0_d;
            gnt_cnt1_q    <= gnt_cnt1_d;
            preempt_cnt_q <= preempt_cnt_d;
        end
    end

    assign gnt_cnt0    = gnt_cnt0_q;
    assign gnt_cnt1    = gnt_cnt1_q;
    assign preempt_cnt = preempt_cnt_q;
`endif

endmodule

// File: tb/tb_mux2_share_arbiter.sv
// Scoreboard bench for mux2_share_arbiter (SETTLE_CYCLES=2, MAX_HOLD=4); per-cycle expectations queued by each scenario.
// Also checks the statistics ports when MUX2_ARB_STATS_EN is defined.
module tb_mux2_share_arbiter;

    localparam int SETTLE = 2;
    localparam int HOLD   = 4;

    typedef struct {
        logic [1:0] gnt;
        logic       sel;
        logic       busy;
        logic       clr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req = 2'b00;
    logic [1:0] gnt;
    logic       sel;
    logic       valid;
    logic       busy;
`ifdef MUX2_ARB_STATS_EN
    logic [15:0] gnt_cnt0;
    logic [15:0] gnt_cnt1;
    logic [7:0]  preempt_cnt;
`endif

    exp_t  exp_q[$];
    string tag_q[$];
    exp_t  mon_e;
    string mon_t;
    int    checks = 0;
    int    errors = 0;
    bit    mon_en = 1'b0;
    logic  sel_prev = 1'b0;
    int    exp_cnt0 = 0;
    int    exp_cnt1 = 0;
    logic [1:0] exp_gnt_prev = 2'b00;

    mux2_share_arbiter #(
        .SETTLE_CYCLES(SETTLE),
        .MAX_HOLD     (HOLD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .gnt        (gnt),
        .sel        (sel),
        .valid      (valid),
`ifdef MUX2_ARB_STATS_EN
        .busy       (busy),
        .gnt_cnt0   (gnt_cnt0),
        .gnt_cnt1   (gnt_cnt1),
        .preempt_cnt(preempt_cnt)
`else
        .busy       (busy)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // Drive one cycle of inputs and queue the outputs expected after the next rising edge.
    task automatic cycle(input logic r, input logic [1:0] rq, input logic [1:0] g,
                         input logic s, input logic b, input string tag);
        exp_t e;
        @(negedge clk);
        rst = r;
        req = rq;
        e.gnt  = g;
        e.sel  = s;
        e.busy = b;
        e.clr  = r;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            checks++;
            if (gnt === 2'b11) begin
                errors++;
                $display("FAIL inv_onehot: gnt=%b, required never 11", gnt);
            end
            checks++;
            if (valid === 1'b1 && sel !== sel_prev) begin
                errors++;
                $display("FAIL inv_sel_stable: sel=%b prev=%b while valid=1, required unchanged", sel, sel_prev);
            end
            checks++;
            if (gnt !== 2'b00 && gnt[sel] !== 1'b1) begin
                errors++;
                $display("FAIL inv_sel_match: gnt=%b sel=%b, required gnt bit at sel", gnt, sel);
            end
        end
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_t = tag_q.pop_front();
            checks++;
            if (gnt !== mon_e.gnt || sel !== mon_e.sel || valid !== (|mon_e.gnt) || busy !== mon_e.busy) begin
                errors++;
                $display("FAIL %s: gnt=%b sel=%b valid=%b busy=%b, required gnt=%b sel=%b valid=%b busy=%b",
                         mon_t, gnt, sel, valid, busy, mon_e.gnt, mon_e.sel, |mon_e.gnt, mon_e.busy);
            end
`ifdef MUX2_ARB_STATS_EN
            if (mon_e.clr) begin
                exp_cnt0 = 0;
                exp_cnt1 = 0;
            end else begin
                if (mon_e.gnt[0] && !exp_gnt_prev[0]) exp_cnt0++;
                if (mon_e.gnt[1] && !exp_gnt_prev[1]) exp_cnt1++;
            end
            exp_gnt_prev = mon_e.gnt;
            checks++;
            if (gnt_cnt0 !== 16'(exp_cnt0) || gnt_cnt1 !== 16'(exp_cnt1)) begin
                errors++;
                $display("FAIL %s_stats: gnt_cnt0=%0d gnt_cnt1=%0d, required %0d %0d",
                         mon_t, gnt_cnt0, gnt_cnt1, exp_cnt0, exp_cnt1);
            end
`endif
            mon_en = 1'b1;
        end
        sel_prev = sel;
    end

    task automatic test_reset();
        cycle(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, "reset0");
        cycle(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, "reset1");
        cycle(1'b0, 2'b01, 2'b01, 1'b0, 1'b1, "first_gnt");
        cycle(1'b0, 2'b01, 2'b01, 1'b0, 1'b1, "first_hold");
        cycle(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, "first_release");
    endtask

    task automatic test_switch_settle();
        cycle(1'b0, 2'b10, 2'b00, 1'b1, 1'b1, "settle_a");
        cycle(1'b0, 2'b10, 2'b00, 1'b1, 1'b1, "settle_b");
        cycle(1'b0, 2'b10, 2'b10, 1'b1, 1'b1, "settle_gnt");
        cycle(1'b0, 2'b00, 2'b00, 1'b1, 1'b0, "settle_release");
    endtask

    task automatic test_round_robin();
        cycle(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, "rr_reset");
        cycle(1'b0, 2'b11, 2'b01, 1'b0, 1'b1, "rr_tie0");
        cycle(1'b0, 2'b11, 2'b01, 1'b0, 1'b1, "rr_tie0_hold");
        for (int i = 0; i < SETTLE; i++) cycle(1'b0, 2'b10, 2'b00, 1'b1, 1'b1, "rr_to1_settle");
        cycle(1'b0, 2'b10, 2'b10, 1'b1, 1'b1, "rr_gnt1");
        for (int i = 0; i < SETTLE; i++) cycle(1'b0, 2'b01, 2'b00, 1'b0, 1'b1, "rr_to0_settle");
        cycle(1'b0, 2'b01, 2'b01, 1'b0, 1'b1, "rr_gnt0");
        cycle(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, "rr_idle");
        for (int i = 0; i < SETTLE; i++) cycle(1'b0, 2'b11, 2'b00, 1'b1, 1'b1, "rr_tie1_settle");
        cycle(1'b0, 2'b11, 2'b10, 1'b1, 1'b1, "rr_tie1");
        cycle(1'b0, 2'b00, 2'b00, 1'b1, 1'b0, "rr_release");
    endtask

    task automatic test_preempt();
        cycle(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, "pre_reset");
        for (int i = 0; i < HOLD; i++) cycle(1'b0, 2'b11, 2'b01, 1'b0, 1'b1, "pre_own0");
        cycle(1'b0, 2'b11, 2'b00, 1'b1, 1'b1, "pre_cut0");
`ifdef MUX2_ARB_STATS_EN
        @(posedge clk);
        #2;
        checks++;
        if (preempt_cnt !== 8'd1) begin
            errors++;
            $display("FAIL preempt_cnt_1: preempt_cnt=%0d, required 1", preempt_cnt);
        end
`endif
        for (int i = 1; i < SETTLE; i++) cycle(1'b0, 2'b11, 2'b00, 1'b1, 1'b1, "pre_settle1");
        for (int i = 0; i < HOLD; i++) cycle(1'b0, 2'b11, 2'b10, 1'b1, 1'b1, "pre_own1");
        for (int i = 0; i < SETTLE; i++) cycle(1'b0, 2'b11, 2'b00, 1'b0, 1'b1, "pre_settle0");
        cycle(1'b0, 2'b11, 2'b01, 1'b0, 1'b1, "pre_back0");
`ifdef MUX2_ARB_STATS_EN
        @(posedge clk);
        #2;
        checks++;
        if (preempt_cnt !== 8'd2) begin
            errors++;
            $display("FAIL preempt_cnt_2: preempt_cnt=%0d, required 2", preempt_cnt);
        end
`endif
        cycle(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, "pre_release");
    endtask

    task automatic test_hold_saturate();
        for (int i = 0; i < 3 * HOLD; i++) cycle(1'b0, 2'b01, 2'b01, 1'b0, 1'b1, "sat_hold");
        cycle(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, "sat_release");
    endtask

    task automatic test_drop_in_settle();
        cycle(1'b0, 2'b10, 2'b00, 1'b1, 1'b1, "drop_settle_a");
        cycle(1'b0, 2'b00, 2'b00, 1'b1, 1'b1, "drop_settle_b");
        cycle(1'b0, 2'b00, 2'b00, 1'b1, 1'b0, "drop_abandon");
        cycle(1'b0, 2'b00, 2'b00, 1'b1, 1'b0, "drop_idle");
    endtask

    task automatic test_reset_mid();
        cycle(1'b0, 2'b10, 2'b10, 1'b1, 1'b1, "mid_gnt");
        cycle(1'b0, 2'b10, 2'b10, 1'b1, 1'b1, "mid_hold");
        cycle(1'b1, 2'b10, 2'b00, 1'b0, 1'b0, "mid_reset");
`ifdef MUX2_ARB_STATS_EN
        @(posedge clk);
        #2;
        checks++;
        if (preempt_cnt !== 8'd0) begin
            errors++;
            $display("FAIL preempt_cnt_clr: preempt_cnt=%0d, required 0", preempt_cnt);
        end
`endif
        cycle(1'b0, 2'b11, 2'b01, 1'b0, 1'b1, "post_reset_tie");
        cycle(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, "post_reset_release");
    endtask

    initial begin
        test_reset();
        test_switch_settle();
        test_round_robin();
        test_preempt();
        test_hold_saturate();
        test_drop_in_settle();
        test_reset_mid();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
